lc3_mem_seq: RTL and testbench

- Memory-access sequencer for the LC-3 datapath.
- On a request from the control unit it:
  - drives the MAR mux and its bus gate to place an address on main_bus;
  - loads MAR;
  - runs the MIO.EN / R handshake with memory;
  - loads MDR on reads.
- Sits between the microsequencer and the MARMUX/MAR/MDR/memory-interface blocks.
- Guarantees the MARMUX gate is enabled only during the address-transfer cycle.

---
 rtl/lc3_mem_seq.sv | 107 ++++++++++
 tb/tb_lc3_mem_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_seq.sv
// LC-3 memory-access sequencer: MARMUX address transfer, MAR load, MIO.EN/R
// handshake with optional timeout, and MDR load on reads.
module lc3_mem_seq #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic we,
  input  logic addr_sel,
  input  logic mem_r,
  output logic marmux_sel,
  output logic gate_marmux,
  output logic ld_mar,
  output logic mio_en,
  output logic r_w,
  output logic ld_mdr,
  output logic busy,
  output logic done,
  output logic err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAR,
    S_ACC,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic             r_we_q;
  logic             r_sel_q;
  logic [CNT_W-1:0] r_cnt;
  logic             w_timeout;

  assign w_timeout = (TIMEOUT != 0) && (r_cnt == LP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_we_q  <= 1'b0;
      r_sel_q <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && req) begin
        r_we_q  <= we;
        r_sel_q <= addr_sel;
        r_cnt   <= '0;
      end else if (r_state == S_ACC && !mem_r) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Moore decode from the state register; only ld_mdr looks at mem_r directly.
  always_comb begin
    w_next      = r_state;
    marmux_sel  = 1'b0;
    gate_marmux = 1'b0;
    ld_mar      = 1'b0;
    mio_en      = 1'b0;
    r_w         = 1'b0;
    ld_mdr      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) w_next = S_MAR;
      end
      S_MAR: begin
        marmux_sel  = r_sel_q;
        gate_marmux = 1'b1;
        ld_mar      = 1'b1;
        busy        = 1'b1;
        w_next      = S_ACC;
      end
      S_ACC: begin
        marmux_sel = r_sel_q;
        mio_en     = 1'b1;
        r_w        = r_we_q;
        busy       = 1'b1;
        ld_mdr     = ~r_we_q & mem_r;
        if (mem_r)          w_next = S_DONE;
        else if (w_timeout) w_next = S_ERR;
      end
      S_DONE: begin
        done   = 1'b1;
        busy   = 1'b1;
        w_next = S_IDLE;
      end
      S_ERR: begin
        err    = 1'b1;
        busy   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lc3_mem_seq.sv
// Bench for lc3_mem_seq: vector table, directed multi-cycle sequences and a
// random run against a transaction-level reference model.
module tb_lc3_mem_seq;

  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst_n, req, we, addr_sel, mem_r;
  logic marmux_sel, gate_marmux, ld_mar, mio_en, r_w, ld_mdr, busy, done, err;
  logic [8:0] outs;

  int n_checks = 0;
  int n_errors = 0;

  lc3_mem_seq #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr_sel(addr_sel),
    .mem_r(mem_r), .marmux_sel(marmux_sel), .gate_marmux(gate_marmux),
    .ld_mar(ld_mar), .mio_en(mio_en), .r_w(r_w), .ld_mdr(ld_mdr),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // {marmux_sel, gate_marmux, ld_mar, mio_en, r_w, ld_mdr, busy, done, err}
  assign outs = {marmux_sel, gate_marmux, ld_mar, mio_en, r_w, ld_mdr, busy, done, err};

  typedef struct {
    logic       req;
    logic       we;
    logic       sel;
    logic       mr;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rq, input logic w, input logic s, input logic mr);
    req = rq; we = w; addr_sel = s; mem_r = mr;
  endtask

  // Reference model: age counts cycles since the request was accepted
  // (0 = idle, 1 = address transfer, k>=2 = (k-1)th memory-access cycle);
  // fin marks the closing cycle (1 = completion, 2 = timeout).
  int   m_age, m_fin;
  logic m_we, m_sel;

  function automatic logic [8:0] model_outs(input logic mr);
    logic [8:0] e;
    e = '0;
    if (m_fin == 1)      e = 9'b000000110;
    else if (m_fin == 2) e = 9'b000000101;
    else if (m_age == 1) e = {m_sel, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    else if (m_age >= 2) e = {m_sel, 1'b0, 1'b0, 1'b1, m_we, ~m_we & mr, 1'b1, 1'b0, 1'b0};
    return e;
  endfunction

  task automatic model_step(input logic rq, input logic w, input logic s, input logic mr);
    if (m_fin != 0) begin
      m_fin = 0;
      m_age = 0;
    end else if (m_age == 0) begin
      if (rq) begin
        m_age = 1; m_we = w; m_sel = s;
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else begin
      if (mr)                           m_fin = 1;
      else if ((m_age - 1) == TIMEOUT)  m_fin = 2;
      else                              m_age++;
    end
  endtask

  initial begin
    int acc_cnt, err_cnt, bad_cnt, done_cnt, first_done, second_mar;
    logic rq, w, s, mr;
    logic [8:0] e;

    // Vector table: inputs for a cycle and the outputs expected in that cycle.
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 9'b000000000};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 9'b111000100};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 9'b100101100};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 9'b000000110};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 9'b000000000};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 9'b000000000};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 9'b011000100};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 9'b000110100};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 9'b000110100};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 9'b000110100};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 9'b000110100};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 9'b000000110};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 9'b000000000};

    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    #2 chk("reset_outs", 32'(outs), 32'd0);
    #10 rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].req, tbl[i].we, tbl[i].sel, tbl[i].mr);
      @(negedge clk);
      chk($sformatf("vec%0d", i), 32'(outs), 32'(tbl[i].exp));
      tick();
    end

    // Timeout: read with mem_r held low.
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    req = 1'b0;
    acc_cnt = 0; err_cnt = 0; bad_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mio_en) acc_cnt++;
      if (err) err_cnt++;
      if (done || ld_mdr) bad_cnt++;
      tick();
    end
    chk("timeout_acc_cycles", 32'(acc_cnt), 32'(TIMEOUT));
    chk("timeout_err_pulses", 32'(err_cnt), 32'd1);
    chk("timeout_no_done_mdr", 32'(bad_cnt), 32'd0);
    @(negedge clk);
    chk("timeout_back_idle", 32'(busy), 32'd0);
    tick();

    // Busy-ignore: we/req toggled during ACC must not affect the access.
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    req = 1'b0;
    tick();
    we = 1'b1; req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ignore_rw_read", 32'({mio_en, r_w}), 32'b10);
      tick();
    end
    req = 1'b0; mem_r = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
      tick();
    end
    chk("ignore_one_done", 32'(done_cnt), 32'd1);

    // Held req: next MAR two cycles after the first done.
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    first_done = -1; second_mar = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done && first_done < 0) first_done = k;
      if (gate_marmux && first_done >= 0 && second_mar < 0) second_mar = k;
      tick();
    end
    chk("held_req_found", 32'(first_done >= 0 && second_mar >= 0), 32'd1);
    chk("held_req_gap", 32'(second_mar - first_done), 32'd2);
    req = 1'b0;
    repeat (4) tick();

    // Asynchronous reset during ACC.
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    req = 1'b0;
    tick();
    @(negedge clk);
    chk("arst_pre_acc", 32'({mio_en, busy}), 32'b11);
    #2 rst_n = 1'b0;
    #1 chk("arst_immediate", 32'(outs), 32'd0);
    mem_r = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("arst_idle_after", 32'(outs), 32'd0);
    end
    tick();

    // Random run against the reference model, with exclusivity checks.
    m_age = 0; m_fin = 0; m_we = 1'b0; m_sel = 1'b0;
    for (int k = 0; k < 10000; k++) begin
      rq = ($urandom_range(0, 2) == 0);
      w  = 1'($urandom_range(0, 1));
      s  = 1'($urandom_range(0, 1));
      mr = ($urandom_range(0, 9) < 3);
      drive(rq, w, s, mr);
      @(negedge clk);
      e = model_outs(mr);
      chk("rand_outs", 32'(outs), 32'(e));
      chk("excl_gate_mio", 32'(gate_marmux & mio_en), 32'd0);
      chk("excl_mdr_write", 32'(ld_mdr & r_w), 32'd0);
      model_step(rq, w, s, mr);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
